// File: rtl/game_timer.sv
// Countdown game timer: BCD seconds display driven by a 1 Hz strobe sampled in the clk domain.
// Start reloads and runs, pause toggles run/pause, and time_up holds after the count expires.
module game_timer #(
  parameter int START_SEC = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       sec_tick,
  output logic       last10,
  output logic       time_up
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] START_TENS = 4'(START_SEC / 10);
  localparam logic [3:0] START_ONES = 4'(START_SEC % 10);

  state_t     state, state_n;
  logic       clk_1hz_d;
  logic       tick;
  logic [3:0] tens_n, ones_n;
  logic       sec_tick_n;
  logic       at_one;

  assign tick   = clk_1hz & ~clk_1hz_d;
  assign at_one = (sec_tens == 4'd0) && (sec_ones == 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_1hz_d <= 1'b0;
      sec_tens  <= START_TENS;
      sec_ones  <= START_ONES;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_n;
      clk_1hz_d <= clk_1hz;
      sec_tens  <= tens_n;
      sec_ones  <= ones_n;
      sec_tick  <= sec_tick_n;
    end
  end

  // Priority: start beats everything, then pause beats a same-cycle tick.
  always_comb begin
    state_n    = state;
    tens_n     = sec_tens;
    ones_n     = sec_ones;
    sec_tick_n = 1'b0;
    if (start) begin
      state_n = RUN;
      tens_n  = START_TENS;
      ones_n  = START_ONES;
    end else begin
      case (state)
        IDLE: begin
          tens_n = START_TENS;
          ones_n = START_ONES;
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (tick) begin
            sec_tick_n = 1'b1;
            if (at_one) begin
              state_n = DONE;
              tens_n  = 4'd0;
              ones_n  = 4'd0;
            end else if (sec_ones == 4'd0) begin
              ones_n = 4'd9;
              tens_n = (sec_tens == 4'd0) ? 4'd0 : sec_tens - 4'd1;
            end else begin
              ones_n = sec_ones - 4'd1;
            end
          end
        end
        PAUSE: begin
          if (pause) state_n = RUN;
        end
        DONE: begin
          tens_n = 4'd0;
          ones_n = 4'd0;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign time_up = (state == DONE);
  assign last10  = ((state == RUN) || (state == PAUSE)) &&
                   ((sec_tens == 4'd0) || ((sec_tens == 4'd1) && (sec_ones == 4'd0)));

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer: a 60 s instance and a 12 s instance share clk, rst, clk_1hz and pause.
// Each instance has its own start so one can run while the other sits idle or done.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_1hz;
  logic       pause;
  logic       start_a, start_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic       running_a, sec_tick_a, last10_a, time_up_a;
  logic       running_b, sec_tick_b, last10_b, time_up_b;

  int tests = 0;
  int failed = 0;
  int cnt_a = 0;
  int cnt_b = 0;
  int snap;

  always #5 clk = ~clk;

  game_timer #(.START_SEC(60)) dut_a (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start(start_a), .pause(pause),
    .sec_tens(tens_a), .sec_ones(ones_a), .running(running_a),
    .sec_tick(sec_tick_a), .last10(last10_a), .time_up(time_up_a)
  );

  game_timer #(.START_SEC(12)) dut_b (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .start(start_b), .pause(pause),
    .sec_tens(tens_b), .sec_ones(ones_b), .running(running_b),
    .sec_tick(sec_tick_b), .last10(last10_b), .time_up(time_up_b)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clk cycle; outputs are sampled 1 ns after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (sec_tick_a) cnt_a++;
    if (sec_tick_b) cnt_b++;
  endtask

  task automatic apply_stimulus(input int n_ticks);
    for (int i = 0; i < n_ticks; i++) begin
      clk_1hz = 1'b1;
      repeat (3) cycle();
      clk_1hz = 1'b0;
      repeat (3) cycle();
    end
  endtask

  initial begin
    rst = 1'b1; clk_1hz = 1'b0; pause = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #2;
    check_output("rst_digits_a", {tens_a, ones_a}, 8'h60);
    check_output("rst_digits_b", {tens_b, ones_b}, 8'h12);
    check_output("rst_flags_a", {running_a, sec_tick_a, last10_a, time_up_a}, 4'b0000);
    cycle();
    rst = 1'b0;
    cycle();

    // 12 s instance runs through borrow, last10 and DONE while A idles.
    start_b = 1'b1; cycle(); start_b = 1'b0;
    check_output("b_start_running", running_b, 1'b1);
    check_output("b_start_digits", {tens_b, ones_b}, 8'h12);
    apply_stimulus(2);
    check_output("b_at_10", {tens_b, ones_b}, 8'h10);
    check_output("b_last10_at_10", last10_b, 1'b1);
    apply_stimulus(1);
    check_output("b_borrow_09", {tens_b, ones_b}, 8'h09);
    apply_stimulus(9);
    check_output("b_done_digits", {tens_b, ones_b}, 8'h00);
    check_output("b_done_flags", {running_b, time_up_b, last10_b}, 3'b010);
    check_output("b_tick_count", cnt_b, 32'd12);
    apply_stimulus(2);
    check_output("b_done_hold", {tens_b, ones_b, time_up_b}, {8'h00, 1'b1});
    check_output("b_no_tick_done", cnt_b, 32'd12);
    check_output("a_idle_ignores_ticks", {tens_a, ones_a, running_a}, {8'h60, 1'b0});
    check_output("a_idle_no_sec_tick", cnt_a, 32'd0);

    // 60 s instance: basic countdown.
    start_a = 1'b1; cycle(); start_a = 1'b0;
    check_output("a_start_running", {running_a, tens_a, ones_a}, {1'b1, 8'h60});
    cnt_a = 0;
    apply_stimulus(3);
    check_output("a_at_57", {tens_a, ones_a}, 8'h57);
    check_output("a_three_ticks", cnt_a, 32'd3);
    apply_stimulus(12);
    check_output("a_at_45", {tens_a, ones_a}, 8'h45);

    pause = 1'b1; cycle(); pause = 1'b0;
    check_output("a_paused", {running_a, last10_a}, 2'b00);
    snap = cnt_a;
    apply_stimulus(5);
    check_output("a_pause_frozen", {tens_a, ones_a}, 8'h45);
    check_output("a_pause_no_tick", cnt_a, snap);
    pause = 1'b1; cycle(); pause = 1'b0;
    check_output("a_resumed", running_a, 1'b1);
    apply_stimulus(1);
    check_output("a_at_44", {tens_a, ones_a}, 8'h44);

    // pause + tick in the same cycle at 30.
    apply_stimulus(14);
    check_output("a_at_30", {tens_a, ones_a}, 8'h30);
    snap = cnt_a;
    clk_1hz = 1'b1; pause = 1'b1; cycle(); pause = 1'b0;
    check_output("a_pause_tick_state", {running_a, tens_a, ones_a}, {1'b0, 8'h30});
    check_output("a_pause_tick_no_tick", cnt_a, snap);
    clk_1hz = 1'b0; repeat (3) cycle();
    pause = 1'b1; cycle(); pause = 1'b0;
    apply_stimulus(10);
    check_output("a_at_20", {running_a, tens_a, ones_a}, {1'b1, 8'h20});

    // start + tick in the same cycle at 20.
    snap = cnt_a;
    clk_1hz = 1'b1; start_a = 1'b1; cycle(); start_a = 1'b0;
    check_output("a_start_tick_reload", {running_a, tens_a, ones_a}, {1'b1, 8'h60});
    check_output("a_start_tick_no_tick", cnt_a, snap);
    clk_1hz = 1'b0; repeat (3) cycle();

    // Asynchronous reset mid-cycle at 33.
    apply_stimulus(27);
    check_output("a_at_33", {tens_a, ones_a}, 8'h33);
    #3;
    rst = 1'b1;
    #1;
    check_output("a_async_rst_digits", {tens_a, ones_a}, 8'h60);
    check_output("a_async_rst_flags", {running_a, sec_tick_a, last10_a, time_up_a}, 4'b0000);
    check_output("b_async_rst", {tens_b, ones_b, time_up_b}, {8'h12, 1'b0});
    clk_1hz = 1'b1;
    cycle();
    rst = 1'b0;
    snap = cnt_a;
    repeat (2) cycle();
    clk_1hz = 1'b0; repeat (3) cycle();
    apply_stimulus(2);
    check_output("a_post_rst_idle", {running_a, tens_a, ones_a}, {1'b0, 8'h60});
    check_output("a_post_rst_no_tick", cnt_a, snap);

    // start + pause in IDLE: start wins.
    start_a = 1'b1; pause = 1'b1; cycle(); start_a = 1'b0; pause = 1'b0;
    check_output("a_start_pause_idle", {running_a, tens_a, ones_a}, {1'b1, 8'h60});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
